// File: rtl/cdim_div_pkg.sv
// Shared types and constants for the iterative divider.
// Enum states, operand width, iteration count, divide-by-zero quotient.
package cdim_div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_ITERS = 32;

  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUO = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } div_state_e;

  // Conditional two's-complement negate.
  function automatic logic [DIV_WIDTH-1:0] div_abs(
    input logic [DIV_WIDTH-1:0] v,
    input logic                 neg
  );
    return neg ? -v : v;
  endfunction

endpackage

// File: rtl/div_ctrl_if.sv
// Operand/result bundle between the E-stage and the divider.
// master drives operands; slave is the divider.
interface div_ctrl_if;
  import cdim_div_pkg::*;

  logic                 start;
  logic                 signed_div;
  logic [DIV_WIDTH-1:0] dividend;
  logic [DIV_WIDTH-1:0] divisor;
  logic                 cancel;
  logic                 div_stall;
  logic                 result_valid;
  logic [DIV_WIDTH-1:0] quotient;
  logic [DIV_WIDTH-1:0] remainder;

  modport master (
    output start, signed_div, dividend, divisor, cancel,
    input  div_stall, result_valid, quotient, remainder
  );

  modport slave (
    input  start, signed_div, dividend, divisor, cancel,
    output div_stall, result_valid, quotient, remainder
  );

endinterface

// File: rtl/div_step.sv
// One restoring radix-2 divide step.
// Shifts the next dividend bit into the partial remainder.
module div_step
  import cdim_div_pkg::*;
(
  input  logic [DIV_WIDTH-1:0] rem,
  input  logic [DIV_WIDTH-1:0] quo,
  input  logic [DIV_WIDTH-1:0] dvs,
  output logic [DIV_WIDTH-1:0] rem_n,
  output logic [DIV_WIDTH-1:0] quo_n
);

  logic [DIV_WIDTH:0] sh;
  logic               ge;

  // Trial subtract; keep the difference only when it fits.
  always_comb begin
    sh    = {rem, quo[DIV_WIDTH-1]};
    ge    = (sh >= {1'b0, dvs});
    rem_n = ge ? (sh[DIV_WIDTH-1:0] - dvs) : sh[DIV_WIDTH-1:0];
    quo_n = {quo[DIV_WIDTH-2:0], ge};
  end

endmodule

// File: rtl/div_ctrl.sv
// Multi-cycle DIV/DIVU controller; stalls E while busy.
// Option: DIV_ZERO_FASTPATH_EN finishes zero-divisor ops at once.
module div_ctrl
  import cdim_div_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  div_ctrl_if.slave  bus
);

  localparam logic [4:0] LAST_CNT = 5'(DIV_ITERS - 1);

  div_state_e state, state_n;

  logic [4:0]           cnt;
  logic [DIV_WIDTH-1:0] rem_r, quo_r, dvs_r;
  logic [DIV_WIDTH-1:0] rem_n, quo_n;
  logic [DIV_WIDTH-1:0] q_r, r_r;
  logic                 sgn_r, sa_r, sb_r, dz_r;
  logic                 load, step, fast, stall, rv;
  logic                 a_neg, b_neg, dz_in, last;
  logic [DIV_WIDTH-1:0] q_fin, r_fin;

  assign a_neg = bus.signed_div & bus.dividend[DIV_WIDTH-1];
  assign b_neg = bus.signed_div & bus.divisor[DIV_WIDTH-1];
  assign dz_in = (bus.divisor == '0);
  assign last  = step & (cnt == LAST_CNT);

  div_step u_step (
    .rem   (rem_r),
    .quo   (quo_r),
    .dvs   (dvs_r),
    .rem_n (rem_n),
    .quo_n (quo_n)
  );

  assign q_fin = dz_r ? DIV_ZERO_QUO
                      : div_abs(quo_n, sgn_r & (sa_r ^ sb_r));
  assign r_fin = div_abs(rem_n, sgn_r & sa_r);

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_n;
  end

  // Next state and control strobes; cancel overrides everything.
  always_comb begin
    state_n = state;
    load    = 1'b0;
    step    = 1'b0;
    fast    = 1'b0;
    stall   = 1'b0;
    rv      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          stall   = 1'b1;
          load    = 1'b1;
          state_n = BUSY;
`ifdef DIV_ZERO_FASTPATH_EN
          if (dz_in) begin
            fast    = 1'b1;
            state_n = DONE;
          end
`endif
        end
      end
      BUSY: begin
        stall = 1'b1;
        step  = 1'b1;
        if (cnt == LAST_CNT) state_n = DONE;
      end
      DONE: begin
        rv      = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (bus.cancel) begin
      state_n = IDLE;
      load    = 1'b0;
      step    = 1'b0;
      fast    = 1'b0;
      stall   = 1'b0;
      rv      = 1'b0;
    end
    if (!resetn) stall = 1'b0;
  end

  // Working registers and registered results.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt   <= '0;
      rem_r <= '0;
      quo_r <= '0;
      dvs_r <= '0;
      sgn_r <= 1'b0;
      sa_r  <= 1'b0;
      sb_r  <= 1'b0;
      dz_r  <= 1'b0;
      q_r   <= '0;
      r_r   <= '0;
    end else begin
      if (load) begin
        cnt   <= '0;
        rem_r <= '0;
        quo_r <= div_abs(bus.dividend, a_neg);
        dvs_r <= div_abs(bus.divisor, b_neg);
        sgn_r <= bus.signed_div;
        sa_r  <= bus.dividend[DIV_WIDTH-1];
        sb_r  <= bus.divisor[DIV_WIDTH-1];
        dz_r  <= dz_in;
      end
      if (fast) begin
        q_r <= DIV_ZERO_QUO;
        r_r <= bus.dividend;
      end
      if (step) begin
        cnt   <= cnt + 5'd1;
        rem_r <= rem_n;
        quo_r <= quo_n;
      end
      if (last) begin
        q_r <= q_fin;
        r_r <= r_fin;
      end
    end
  end

  assign bus.div_stall    = stall;
  assign bus.result_valid = rv;
  assign bus.quotient     = q_r;
  assign bus.remainder    = r_r;

endmodule
